// File: rtl/dram_wr_pkg.sv
// Shared types and helpers for the single-clock DRAM write packer.
package dram_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_WAIT_PEND,
    ST_DONE
  } wr_state_e;

  localparam int DEF_DATA_IN_WIDTH = 16;
  localparam int DEF_OUTPUT_WIDTH  = 32;
  localparam int DEF_FIFO_DEPTH    = 16;
  localparam int DEF_R             = DEF_OUTPUT_WIDTH / DEF_DATA_IN_WIDTH;
  localparam int DEF_R_LOG2        = $clog2(DEF_R);
  localparam int DEF_FIFO_LOG2     = $clog2(DEF_FIFO_DEPTH);

  // Cycles spent in WAIT_PEND before dram_wr_pending is trusted.
  localparam int GUARD_CYCLES = 2;

  function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    return (num + den - 32'd1) / den;
  endfunction

endpackage

// File: rtl/dram_wr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
module dram_wr_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_wr, do_rd;

  assign full  = cnt_q == (PTR_W+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign rdata = mem_q[rd_ptr_q];
  assign do_wr = push & ~full;
  assign do_rd = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/dram_wr_packer.sv
// Packs narrow elements R-per-word, buffers them and issues sequential DRAM writes.
module dram_wr_packer import dram_wr_pkg::*; #(
  parameter int ADDR_WIDTH    = 15,
  parameter int SIZE_WIDTH    = 17,
  parameter int DATA_IN_WIDTH = DEF_DATA_IN_WIDTH,
  parameter int OUTPUT_WIDTH  = DEF_OUTPUT_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int LANE_REVERSE  = 1,
  localparam int R            = OUTPUT_WIDTH / DATA_IN_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic                     abort,
  input  logic [ADDR_WIDTH-1:0]    start_addr,
  input  logic [SIZE_WIDTH-1:0]    size,
  input  logic                     wr_en,
  input  logic [DATA_IN_WIDTH-1:0] data,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  input  logic                     dram_ready,
  output logic                     dram_wr_en,
  output logic [ADDR_WIDTH-1:0]    dram_wr_addr,
  output logic [OUTPUT_WIDTH-1:0]  dram_wr_data,
  output logic [R-1:0]             dram_wr_mask,
  input  logic                     dram_wr_pending
);
  localparam int LANE_W = (R > 1) ? $clog2(R) : 1;
  localparam int FW     = OUTPUT_WIDTH + R + 1;

  wr_state_e               state_q, state_d;
  logic [SIZE_WIDTH-1:0]   size_q, size_d, in_cnt_q, in_cnt_d;
  logic [SIZE_WIDTH:0]     n_words_q, n_words_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d, word_idx_q, word_idx_d;
  logic [OUTPUT_WIDTH-1:0] pack_q, pack_d, word_ins;
  logic [R-1:0]            pmask_q, pmask_d, mask_ins;
  logic [1:0]              guard_q, guard_d;
  logic [LANE_W-1:0]       lane;
  logic                    accept, tail, push, pop, last_pop, flush;
  logic                    fifo_full, fifo_empty;
  logic [FW-1:0]           head;

  assign lane   = LANE_W'(in_cnt_q & SIZE_WIDTH'(R - 1));
  assign accept = wr_en & ready;
  assign tail   = (in_cnt_q + SIZE_WIDTH'(1)) == size_q;
  assign push   = accept & ((int'(lane) == R - 1) | tail);
  assign pop    = dram_wr_en;
  assign last_pop = pop & head[FW-1];
  assign flush  = abort & (state_q != ST_IDLE);

  // Merge the incoming element into its lane; the result is either pushed or held.
  always_comb begin
    word_ins = pack_q;
    mask_ins = pmask_q;
    for (int i = 0; i < R; i++) begin
      if (int'(lane) == i) begin
        word_ins[((LANE_REVERSE != 0) ? (R - 1 - i) : i) * DATA_IN_WIDTH +: DATA_IN_WIDTH] = data;
        mask_ins[i] = 1'b1;
      end
    end
  end

  dram_wr_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata ({tail, mask_ins, word_ins}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready        = (state_q == ST_FILL) & ~fifo_full & (in_cnt_q < size_q);
  assign busy         = state_q != ST_IDLE;
  assign done         = state_q == ST_DONE;
  assign dram_wr_en   = ~fifo_empty & dram_ready & ((state_q == ST_FILL) | (state_q == ST_DRAIN));
  assign dram_wr_addr = base_q + word_idx_q;
  assign dram_wr_data = fifo_empty ? '0 : head[OUTPUT_WIDTH-1:0];
  assign dram_wr_mask = fifo_empty ? '0 : head[OUTPUT_WIDTH +: R];

  // A zero-length burst passes through FILL once, so done lands two cycles after go.
  always_comb begin
    state_d = state_q;
    guard_d = '0;
    case (state_q)
      ST_IDLE:  if (go) state_d = ST_FILL;
      ST_FILL: begin
        if (n_words_q == '0)          state_d = ST_DONE;
        else if (last_pop)            state_d = ST_WAIT_PEND;
        else if (in_cnt_q == size_q)  state_d = ST_DRAIN;
      end
      ST_DRAIN: if (last_pop) state_d = ST_WAIT_PEND;
      ST_WAIT_PEND: begin
        if (guard_q != 2'(GUARD_CYCLES)) begin
          guard_d = guard_q + 2'd1;
        end else begin
          guard_d = guard_q;
          if (!dram_wr_pending) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    size_d     = size_q;
    n_words_d  = n_words_q;
    base_d     = base_q;
    in_cnt_d   = in_cnt_q;
    word_idx_d = word_idx_q;
    pack_d     = pack_q;
    pmask_d    = pmask_q;
    if (state_q == ST_IDLE) begin
      if (go) begin
        size_d     = size;
        n_words_d  = (SIZE_WIDTH+1)'(ceil_div(32'(size), 32'(R)));
        base_d     = start_addr;
        in_cnt_d   = '0;
        word_idx_d = '0;
        pack_d     = '0;
        pmask_d    = '0;
      end
    end else if (flush) begin
      pack_d  = '0;
      pmask_d = '0;
    end else begin
      if (accept) begin
        in_cnt_d = in_cnt_q + SIZE_WIDTH'(1);
        pack_d   = push ? '0 : word_ins;
        pmask_d  = push ? '0 : mask_ins;
      end
      if (pop) word_idx_d = word_idx_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      size_q     <= '0;
      n_words_q  <= '0;
      base_q     <= '0;
      in_cnt_q   <= '0;
      word_idx_q <= '0;
      pack_q     <= '0;
      pmask_q    <= '0;
      guard_q    <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      n_words_q  <= n_words_d;
      base_q     <= base_d;
      in_cnt_q   <= in_cnt_d;
      word_idx_q <= word_idx_d;
      pack_q     <= pack_d;
      pmask_q    <= pmask_d;
      guard_q    <= guard_d;
    end
  end
endmodule

// File: tb/tb_dram_wr_packer.sv
// Directed bench for dram_wr_packer with a word-level reference model and a per-cycle checker.
module tb_dram_wr_packer;
  localparam int R   = 2;
  localparam int REV = 1;

  logic        clk = 1'b0;
  logic        rst_n, go, abort, wr_en, dram_ready, dram_wr_pending;
  logic [14:0] start_addr;
  logic [16:0] size;
  logic [15:0] data;
  logic        ready, busy, done, dram_wr_en;
  logic [14:0] dram_wr_addr;
  logic [31:0] dram_wr_data;
  logic [1:0]  dram_wr_mask;

  dram_wr_packer dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .start_addr(start_addr), .size(size),
    .wr_en(wr_en), .data(data), .ready(ready), .busy(busy), .done(done),
    .dram_ready(dram_ready), .dram_wr_en(dram_wr_en), .dram_wr_addr(dram_wr_addr),
    .dram_wr_data(dram_wr_data), .dram_wr_mask(dram_wr_mask), .dram_wr_pending(dram_wr_pending)
  );

  always #5 clk = ~clk;

  typedef struct { logic [14:0] a; logic [31:0] d; logic [1:0] m; } wr_t;
  wr_t         exp_q[$];
  logic [14:0] log_a[$];
  logic [31:0] log_d[$];
  logic [1:0]  log_m[$];
  int tests = 0, fails = 0, cyc = 0, fed = 0;
  int done_cnt = 0, last_done_cyc = -1, exp_done_cyc = -1;
  int wp_cyc = 0, n0, go_cyc, fall_cyc, c;
  bit track = 0, wp_arm = 0;
  wr_t ce;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Expected words straight from the burst description: word j holds elements j*R..j*R+R-1.
  task automatic build_exp(input int a, input int s, input int base);
    int nw;
    nw = (s + R - 1) / R;
    for (int j = 0; j < nw; j++) begin
      wr_t e;
      e.a = 15'((a + j) % 32768);
      e.d = '0;
      e.m = '0;
      for (int i = 0; i < R; i++) begin
        if (j * R + i < s) begin
          e.d[16 * ((REV != 0) ? (R - 1 - i) : i) +: 16] = 16'(base + j * R + i);
          e.m[i] = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic start_burst(input int a, input int s, input int base, input bit model);
    go = 1'b1; start_addr = 15'(a); size = 17'(s);
    if (s == 0) exp_done_cyc = cyc + 2;
    else if (model) begin build_exp(a, s, base); track = 1'b1; end
    go_cyc = cyc;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic feed(input int n, input int base);
    int k, cnt;
    logic acc;
    k = 0; cnt = 0;
    while (k < n && cnt < 400) begin
      wr_en = 1'b1; data = 16'(base + k);
      @(negedge clk); acc = ready;
      @(posedge clk); #1; cnt++;
      if (acc) begin k++; fed++; end
    end
    wr_en = 1'b0;
    if (k < n) chk("feed_timeout", k, n);
  endtask

  task automatic wait_done(input int n_before);
    int cnt;
    cnt = 0;
    while (done_cnt == n_before && cnt < 300) begin @(posedge clk); #1; cnt++; end
    chk("done_seen", done_cnt, n_before + 1);
  endtask

  task automatic clear_log();
    log_a.delete(); log_d.delete(); log_m.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wr_en"}, dram_wr_en, 0);
    chk({tag, "_addr"}, dram_wr_addr, 0);
    chk({tag, "_data"}, dram_wr_data, 0);
    chk({tag, "_mask"}, dram_wr_mask, 0);
  endtask

  // Per-cycle checker: issued words against the model queue, done against its predicted cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done || cyc == exp_done_cyc) chk("done_pulse", done, cyc == exp_done_cyc);
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (cyc == exp_done_cyc) exp_done_cyc = -1;
      if (dram_wr_en) begin
        chk("wr_en_needs_ready", dram_ready, 1);
        log_a.push_back(dram_wr_addr); log_d.push_back(dram_wr_data); log_m.push_back(dram_wr_mask);
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          ce = exp_q.pop_front();
          chk("wr_addr", dram_wr_addr, ce.a);
          chk("wr_data", dram_wr_data, ce.d);
          chk("wr_mask", dram_wr_mask, ce.m);
          if (exp_q.size() == 0 && track) begin wp_cyc = cyc; wp_arm = 1'b1; track = 1'b0; end
        end
      end
      if (wp_arm && cyc >= wp_cyc + 3 && !dram_wr_pending) begin
        exp_done_cyc = cyc + 1;
        wp_arm = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; go = 0; abort = 0; start_addr = '0; size = '0; wr_en = 0; data = '0;
    dram_ready = 1; dram_wr_pending = 0;
    repeat (3) @(posedge clk); #1;
    check_zero("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Odd tail
    clear_log(); n0 = done_cnt;
    start_burst('h10, 5, 1, 1);
    feed(5, 1);
    wait_done(n0);
    chk("tail_nwr", log_a.size(), 3);
    if (log_a.size() >= 3) begin
      chk("tail_a0", log_a[0], 15'h10); chk("tail_d0", log_d[0], 32'h0001_0002); chk("tail_m0", log_m[0], 2'b11);
      chk("tail_a1", log_a[1], 15'h11); chk("tail_d1", log_d[1], 32'h0003_0004); chk("tail_m1", log_m[1], 2'b11);
      chk("tail_a2", log_a[2], 15'h12); chk("tail_d2", log_d[2], 32'h0005_0000); chk("tail_m2", log_m[2], 2'b01);
    end

    // Backpressure: FIFO of 16 words holds 32 elements
    clear_log(); n0 = done_cnt; fed = 0; dram_ready = 0;
    start_burst('h100, 40, 'h100, 1);
    fork feed(40, 'h100); join_none
    c = 0;
    while (fed < 32 && c < 200) begin @(posedge clk); #1; c++; end
    repeat (4) begin @(posedge clk); #1; end
    chk("bp_accepted", fed, 32);
    chk("bp_ready_low", ready, 0);
    chk("bp_no_writes", log_a.size(), 0);
    dram_ready = 1;
    wait_done(n0);
    chk("bp_nwr", log_a.size(), 20);
    chk("bp_all_issued", exp_q.size(), 0);
    if (log_a.size() >= 20) begin
      chk("bp_last_addr", log_a[19], 15'h113);
      chk("bp_last_data", log_d[19], 32'h0126_0127);
    end

    // Address wrap
    clear_log(); n0 = done_cnt;
    start_burst('h7FFF, 4, 'hB0, 1);
    feed(4, 'hB0);
    wait_done(n0);
    chk("wrap_nwr", log_a.size(), 2);
    if (log_a.size() >= 2) begin
      chk("wrap_a0", log_a[0], 15'h7FFF);
      chk("wrap_a1", log_a[1], 15'h0000);
      chk("wrap_d0", log_d[0], 32'h00B0_00B1);
    end

    // Pending hold, with a stray go mid-burst
    clear_log(); n0 = done_cnt; dram_wr_pending = 1;
    start_burst('h20, 6, 'h30, 1);
    go = 1; size = '0; start_addr = 15'h55;
    @(posedge clk); #1;
    go = 0;
    feed(6, 'h30);
    c = 0;
    while (exp_q.size() != 0 && c < 300) begin @(posedge clk); #1; c++; end
    repeat (10) @(posedge clk);
    #1;
    dram_wr_pending = 0; fall_cyc = cyc;
    wait_done(n0);
    chk("pend_done_cyc", last_done_cyc, fall_cyc + 1);
    chk("pend_nwr", log_a.size(), 3);

    // Abort after 3 of 8, then restart
    clear_log(); n0 = done_cnt; dram_ready = 0;
    start_burst('h30, 8, 'h70, 0);
    feed(3, 'h70);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_busy", busy, 0);
    dram_ready = 1;
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_writes", log_a.size(), 0);
    chk("abort_no_done", done_cnt, n0);
    start_burst('h40, 2, 'h90, 1);
    feed(2, 'h90);
    wait_done(n0);
    chk("restart_nwr", log_a.size(), 1);
    if (log_a.size() >= 1) begin
      chk("restart_a0", log_a[0], 15'h40);
      chk("restart_d0", log_d[0], 32'h0090_0091);
    end

    // Zero-size burst
    clear_log(); n0 = done_cnt;
    start_burst('h50, 0, 0, 1);
    wait_done(n0);
    chk("zero_done_cyc", last_done_cyc, go_cyc + 2);
    chk("zero_nwr", log_a.size(), 0);

    // Reset mid-burst
    clear_log(); dram_ready = 0;
    start_burst('h60, 8, 'hA0, 0);
    feed(4, 'hA0);
    rst_n = 0;
    @(posedge clk); #1;
    check_zero("midrst");
    rst_n = 1; dram_ready = 1;
    repeat (5) begin @(posedge clk); #1; end
    chk("midrst_no_writes", log_a.size(), 0);
    chk("midrst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
